mul_div_unit: RTL and testbench

Multi-cycle signed 32-bit multiply/divide unit feeding the datapath's Z register pair. It captures operand A from the Y register and operand B from the bus when started. It iterates one bit per clock, then presents a 64-bit result as `z_high`/`z_low` for loading into Zhigh/Zlow. Control raises `start`, waits for `done`, then asserts the Zhigh/Zlow enables.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/addsub_w1.sv | 13 +
 rtl/mul_div_unit.sv | 179 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the multi-cycle multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned MULDIV_WIDTH = 32;

  typedef logic [1:0] muldiv_state_t;

  localparam muldiv_state_t IDLE = 2'd0;
  localparam muldiv_state_t RUN  = 2'd1;
  localparam muldiv_state_t FIX  = 2'd2;
  localparam muldiv_state_t DONE = 2'd3;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

endpackage

// File: rtl/addsub_w1.sv
// Combinational WIDTH+1-bit adder/subtractor shared by the Booth and non-restoring steps.
module addsub_w1 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0] x,
  input  logic [WIDTH:0] y,
  input  logic           sub,
  output logic [WIDTH:0] sum
);

  assign sum = sub ? (x - y) : (x + y);

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (non-restoring) unit, one bit per clock.
// Divide support is compiled in only when MULDIV_DIVIDE_EN is defined.
module mul_div_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = MULDIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] z_high,
  output logic [WIDTH-1:0] z_low,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned AW = 2 * WIDTH + 1;

  muldiv_state_t    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] z_high_q, z_high_d, z_low_q, z_low_d;
  logic             dbz_q, dbz_d;
  logic [WIDTH:0]   as_x, as_y, as_r;
  logic             as_sub;

`ifdef MULDIV_DIVIDE_EN
  logic             neg_a_q, neg_a_d, neg_b_q, neg_b_d, dz_q, dz_d;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;

  assign a_mag = a[WIDTH-1] ? -a : a;
  assign b_mag = b[WIDTH-1] ? -b : b;
  // acc holds {remainder(WIDTH+1), quotient(WIDTH)} during a divide.
  assign quo   = acc_q[WIDTH-1:0];
  assign rem   = acc_q[AW-1] ? as_r[WIDTH-1:0] : acc_q[AW-2:WIDTH];
`endif

  addsub_w1 #(.WIDTH(WIDTH)) u_addsub (
    .x  (as_x),
    .y  (as_y),
    .sub(as_sub),
    .sum(as_r)
  );

  // Booth: acc = {high(WIDTH), multiplier(WIDTH), q_-1}; high is sign-extended into the adder.
  always_comb begin
    as_x   = {acc_q[AW-1], acc_q[AW-1:WIDTH+1]};
    as_y   = {m_q[WIDTH-1], m_q};
    as_sub = (acc_q[1:0] == 2'b10);
`ifdef MULDIV_DIVIDE_EN
    if (op_q == OP_DIV) begin
      as_y = {1'b0, m_q};
      if (state_q == FIX) begin
        as_x   = acc_q[AW-1:WIDTH];
        as_sub = 1'b0;
      end else begin
        as_x   = {acc_q[AW-2:WIDTH], acc_q[WIDTH-1]};
        as_sub = ~acc_q[AW-1];
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    m_d      = m_q;
    acc_d    = acc_q;
    z_high_d = z_high_q;
    z_low_d  = z_low_q;
    dbz_d    = dbz_q;
`ifdef MULDIV_DIVIDE_EN
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    dz_d     = dz_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = CW'(WIDTH);
          op_d    = op;
          m_d     = a;
          acc_d   = {{WIDTH{1'b0}}, b, 1'b0};
`ifdef MULDIV_DIVIDE_EN
          neg_a_d = a[WIDTH-1];
          neg_b_d = b[WIDTH-1];
          dz_d    = (op == OP_DIV) && (b == '0);
          if (op == OP_DIV) begin
            m_d   = b_mag;
            acc_d = {{(WIDTH + 1){1'b0}}, a_mag};
          end
`endif
        end
      end
      RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CW'(1)) state_d = FIX;
        if (op_q == OP_MUL) begin
          acc_d = {((acc_q[1] ^ acc_q[0]) ? as_r : as_x), acc_q[WIDTH:1]};
        end
`ifdef MULDIV_DIVIDE_EN
        // Divide-by-zero freezes acc so |a| is still available to rebuild z_high.
        else if (!dz_q) begin
          acc_d = {as_r, acc_q[WIDTH-2:0], ~as_r[WIDTH]};
        end
`endif
      end
      FIX: begin
        state_d  = DONE;
        z_high_d = '0;
        z_low_d  = '0;
        dbz_d    = 1'b0;
        if (op_q == OP_MUL) begin
          {z_high_d, z_low_d} = acc_q[AW-1:1];
        end
`ifdef MULDIV_DIVIDE_EN
        else if (dz_q) begin
          z_high_d = neg_a_q ? -quo : quo;
          z_low_d  = '1;
          dbz_d    = 1'b1;
        end else begin
          z_high_d = neg_a_q ? -rem : rem;
          z_low_d  = (neg_a_q ^ neg_b_q) ? -quo : quo;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= OP_MUL;
      m_q      <= '0;
      acc_q    <= '0;
      z_high_q <= '0;
      z_low_q  <= '0;
      dbz_q    <= 1'b0;
`ifdef MULDIV_DIVIDE_EN
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      dz_q     <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      m_q      <= m_d;
      acc_q    <= acc_d;
      z_high_q <= z_high_d;
      z_low_q  <= z_low_d;
      dbz_q    <= dbz_d;
`ifdef MULDIV_DIVIDE_EN
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      dz_q     <= dz_d;
`endif
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign z_high      = z_high_q;
  assign z_low       = z_low_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences, random vs model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, div_by_zero;
  logic [31:0] z_high, z_low;

  int tests = 0;
  int fails = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .clr        (clr),
    .start      (start),
    .op         (op),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .z_high     (z_high),
    .z_low      (z_low),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: plain signed arithmetic; returns {dbz, hi, lo}.
  function automatic logic [64:0] model(input logic o, input logic [31:0] av, input logic [31:0] bv);
    longint pa, pb, p;
    int sa, sb;
    if (o == 1'b0) begin
      pa = {{32{av[31]}}, av};
      pb = {{32{bv[31]}}, bv};
      p  = pa * pb;
      return {1'b0, p};
    end
`ifdef MULDIV_DIVIDE_EN
    if (bv == 32'd0) return {1'b1, av, 32'hFFFF_FFFF};
    if (av == 32'h8000_0000 && bv == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
    sa = av;
    sb = bv;
    return {1'b0, 32'(sa % sb), 32'(sa / sb)};
`else
    sa = 0;
    sb = 0;
    return '0;
`endif
  endfunction

  // Runs one operation; optionally re-raises start during RUN and during done.
  task automatic do_op(input string name, input logic o, input logic [31:0] av,
                       input logic [31:0] bv, input bit spam, input logic [31:0] eh,
                       input logic [31:0] el, input logic ed);
    int lat, fall;
    lat  = 0;
    fall = 0;
    @(negedge clk);
    start = 1'b1;
    op    = o;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    op    = ~o;
    for (int k = 1; k <= 60 && fall == 0; k++) begin
      @(posedge clk);
      #1;
      if (done && lat == 0) lat = k;
      if (!busy) fall = k;
      start = spam && (k == 5 || done);
      if (start) begin
        a = $urandom;
        b = $urandom;
      end
    end
    start = 1'b0;
    check({name, " done latency"}, lat, 33);
    check({name, " busy fall"}, fall, 34);
    repeat (2) @(posedge clk);
    #1;
    check({name, " idle after"}, busy, 1'b0);
    check({name, " z_high"}, z_high, eh);
    check({name, " z_low"}, z_low, el);
    check({name, " div_by_zero"}, div_by_zero, ed);
  endtask

  initial begin
    logic [64:0] m;
    logic        ro;
    logic [31:0] ra, rb, eh, el;
    logic        ed;

    vecs[0]  = '{1'b0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFEF,  32'd5,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'd17,         32'hFFFF_FFFB, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0};
    vecs[4]  = '{1'b1, 32'd42,         32'd0,         32'd42,        32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{1'b0, 32'd3,          32'd4,         32'd0,         32'd12,        1'b0};
    vecs[6]  = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'd100,        32'd7,         32'd2,         32'd14,        1'b0};
    vecs[8]  = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd0,         32'd1,         1'b0};
    vecs[9]  = '{1'b0, 32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[10] = '{1'b1, 32'd10,         32'd2,         32'd0,         32'd5,         1'b0};
    vecs[11] = '{1'b1, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd3,         1'b0};
    vecs[12] = '{1'b1, 32'h8000_0000,  32'd0,         32'h8000_0000, 32'hFFFF_FFFF, 1'b1};

    #12;
    check("reset outputs", {busy, done, div_by_zero, z_high, z_low}, 67'd0);
    @(negedge clk);
    clr = 1'b0;

    foreach (vecs[i]) begin
      eh = vecs[i].hi;
      el = vecs[i].lo;
      ed = vecs[i].dbz;
`ifndef MULDIV_DIVIDE_EN
      if (vecs[i].op) begin
        eh = '0;
        el = '0;
        ed = 1'b0;
      end
`endif
      do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, eh, el, ed);
    end

    // start re-raised during RUN and during done must be ignored.
    do_op("spam", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);

    // clr in the middle of RUN clears everything at once.
    @(negedge clk);
    start = 1'b1;
    op    = 1'b0;
    a     = 32'd1000;
    b     = 32'd1000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("busy mid run", busy, 1'b1);
    clr = 1'b1;
    #1;
    check("clr outputs", {busy, done, div_by_zero, z_high, z_low}, 67'd0);
    @(negedge clk);
    clr = 1'b0;
    m = model(1'b0, 32'hFFFF_FF9C, 32'd12345);
    do_op("after clr", 1'b0, 32'hFFFF_FF9C, 32'd12345, 1'b0, m[63:32], m[31:0], m[64]);

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom_range(0, 1));
      ra = (i % 3 == 0) ? 32'(int'($urandom_range(0, 200)) - 100) : $urandom;
      case ($urandom_range(0, 3))
        0:       rb = 32'd0;
        1:       rb = 32'(int'($urandom_range(0, 30)) - 15);
        default: rb = $urandom;
      endcase
      m = model(ro, ra, rb);
      do_op($sformatf("rand%0d op%0d a=%0h b=%0h", i, ro, ra, rb), ro, ra, rb, 1'b0,
            m[63:32], m[31:0], m[64]);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
